// File: rtl/sos_morse_tx.sv
// sos_morse_tx: emits one Morse "S O S" word on a single serial line per
// start pulse. Element timing is derived from UNIT_CYCLES clocks per unit.
// Optional build macro SOS_TX_REPEAT_EN adds the repeat_mode input and the
// WGAP word gap so the word can loop continuously.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start, line low
// MARK   | line high for a dot (1 unit) or dash (3 units)
// ESPACE | 1-unit gap between elements of one letter
// LGAP   | 3-unit gap between letters
// WGAP   | 7-unit gap between repeated words (SOS_TX_REPEAT_EN only)

module sos_morse_tx #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef SOS_TX_REPEAT_EN
  input  logic       repeat_mode,
`endif
  output logic       out,
  output logic       busy,
  output logic       done,
  output logic [1:0] letter_idx,
  output logic [2:0] current_state
);

`ifdef SOS_TX_REPEAT_EN
  // The word gap is 7 units, longer than any element, so the counter is sized for it.
  localparam int CW = $clog2(7 * UNIT_CYCLES) + 1;
`else
  localparam int CW = $clog2(3 * UNIT_CYCLES) + 1;
`endif

  localparam logic [CW-1:0] TC_UNIT = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] TC_DASH = CW'(3 * UNIT_CYCLES - 1);
`ifdef SOS_TX_REPEAT_EN
  localparam logic [CW-1:0] TC_WORD = CW'(7 * UNIT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MARK   = 3'd1,
    ESPACE = 3'd2,
`ifdef SOS_TX_REPEAT_EN
    LGAP   = 3'd3,
    WGAP   = 3'd4
`else
    LGAP   = 3'd3
`endif
  } state_t;

  state_t          state;
  logic [CW-1:0]   unit_cnt;
  logic [1:0]      elem_cnt;
  logic [CW-1:0]   mark_tc;
`ifdef SOS_TX_REPEAT_EN
  logic            rep_armed;
`endif

  assign current_state = state;

  // The middle letter (O) is built from dashes; both S letters from dots.
  always_comb begin
    mark_tc = TC_UNIT;
    if (letter_idx == 2'd1) mark_tc = TC_DASH;
  end

  // Sequencer: all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      unit_cnt   <= '0;
      elem_cnt   <= '0;
      letter_idx <= '0;
      out        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SOS_TX_REPEAT_EN
      rep_armed  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          unit_cnt   <= '0;
          elem_cnt   <= '0;
          letter_idx <= '0;
          if (start) begin
            state <= MARK;
            out   <= 1'b1;
            busy  <= 1'b1;
`ifdef SOS_TX_REPEAT_EN
            rep_armed <= repeat_mode;
`endif
          end
        end

        MARK: begin
          if (unit_cnt == mark_tc) begin
            unit_cnt <= '0;
            out      <= 1'b0;
            if (elem_cnt != 2'd2) begin
              state <= ESPACE;
            end else if (letter_idx != 2'd2) begin
              state <= LGAP;
`ifdef SOS_TX_REPEAT_EN
            end else if (repeat_mode || rep_armed) begin
              // A word that started in repeat mode always gets its word gap;
              // the decision to stop is taken at the end of that gap.
              state    <= WGAP;
              elem_cnt <= '0;
`endif
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              elem_cnt   <= '0;
              letter_idx <= '0;
            end
          end else begin
            unit_cnt <= unit_cnt + CW'(1);
          end
        end

        ESPACE: begin
          if (unit_cnt == TC_UNIT) begin
            unit_cnt <= '0;
            elem_cnt <= elem_cnt + 2'd1;
            state    <= MARK;
            out      <= 1'b1;
          end else begin
            unit_cnt <= unit_cnt + CW'(1);
          end
        end

        LGAP: begin
          if (unit_cnt == TC_DASH) begin
            unit_cnt   <= '0;
            elem_cnt   <= '0;
            letter_idx <= letter_idx + 2'd1;
            state      <= MARK;
            out        <= 1'b1;
          end else begin
            unit_cnt <= unit_cnt + CW'(1);
          end
        end

`ifdef SOS_TX_REPEAT_EN
        WGAP: begin
          if (unit_cnt == TC_WORD) begin
            unit_cnt   <= '0;
            elem_cnt   <= '0;
            letter_idx <= '0;
            if (repeat_mode) begin
              state     <= MARK;
              out       <= 1'b1;
              rep_armed <= 1'b1;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              rep_armed <= 1'b0;
            end
          end else begin
            unit_cnt <= unit_cnt + CW'(1);
          end
        end
`endif

        default: begin
          state      <= IDLE;
          unit_cnt   <= '0;
          elem_cnt   <= '0;
          letter_idx <= '0;
          out        <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
